imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory writer for the MIPS pipeline. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit R/I/J words, using the same bit layout the pipeline's field decoder splits apart. It writes the words to consecutive instruction-memory addresses from 0, then terminates the program with the halt sentinel 32'hFFFFFFFF that the fetch stage's stop detector recognises. It sits between the testbench/boot source and the instruction memory write port.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  loader can accept a request
- finish  in  1  qualifies request as "terminate program"; the field inputs are ignored when it is 1
- fmt  in  2  00 R-type, 01 I-type, 10 J-type, 11 raw
- op  in  6  opcode
- rs, rt, rd, shamt  in  5 each  register/shift fields
- funct  in  6  function field
- imm  in  16  immediate
- jaddress  in  26  jump target field
- raw  in  32  verbatim word (fmt=11)
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory read data, combinational read of mem_addr (used only with readback)
- count  out  ADDR_W+1  words written so far, including the sentinel
- done  out  1  sentinel written; loader idle until reset
- err  out  1  sticky error flag

## Operation
- Encoding:
  - R: {op,rs,rt,rd,shamt,funct}
  - I: {op,rs,rt,imm}
  - J: {op,jaddress}
  - raw: raw
- Transfer: occurs when in_valid & in_ready on a rising edge.
- in_ready = (state==IDLE) & ~reset.
- FSM states: IDLE, WRITE, VERIFY (readback builds only), DONE.
- IDLE, transfer with finish=0:
  - If ptr == 2^ADDR_W-1 (last slot, reserved for the sentinel): set err, drop the word, stay IDLE.
  - Else if the encoded word == 32'hFFFFFFFF: set err, drop the word, stay IDLE (a premature halt is not allowed).
  - Else: latch the word and go to WRITE.
- IDLE, transfer with finish=1: latch 32'hFFFFFFFF and go to WRITE with the last-word flag set.
- WRITE:
  - mem_we=1, mem_addr=ptr, mem_wdata=latched word.
  - ptr++ and count++.
  - Next state is DONE if the last-word flag is set, else IDLE (or VERIFY in readback builds).
- DONE: in_ready=0, mem_we=0, done=1. Held until reset.
- The sentinel always fits, because the last slot is reserved for it.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err=0, ptr=0, state=IDLE. in_ready reads 0 while reset is high and 1 after.
- Reset mid-operation: reset in WRITE or VERIFY aborts the operation. If reset is high during the WRITE cycle, mem_we is forced to 0 in that cycle; the memory contents are not cleared.

## Timing
- Transfer at edge t:
  - mem_we high for exactly the cycle t..t+1.
  - in_ready low during that cycle and high again from t+1 (no readback) or t+2 (readback).
- Maximum throughput is one word per 2 cycles (per 3 cycles with readback).
- Address: the k-th accepted word is written at address k-1.
- count updates at the edge that ends the WRITE cycle.
- done rises at the edge ending the sentinel WRITE cycle and stays high.
- err rises at the edge following the rejected transfer; a rejected transfer does not drop in_ready.
- in_valid while in_ready=0 is ignored; the requester must hold the request stable until it is accepted.

## Configuration
- IMEM_LOADER_READBACK_EN defined:
  - After each WRITE, the loader spends one VERIFY cycle with mem_we=0 and mem_addr at the just-written address (ptr-1), and compares mem_rdata to the latched word.
  - A mismatch sets err.
  - VERIFY then goes to IDLE, or to DONE for the sentinel.
- Not defined: no VERIFY state, mem_rdata is unused, WRITE goes directly to IDLE/DONE.

## Test plan
- R-type op=0, rs=8, rt=9, rd=10, shamt=0, funct=6'h20, then finish -> writes 32'h01095020 @0 and 32'hFFFFFFFF @1; count=2; done=1; err=0.
- I-type op=6'h23, rs=29, rt=8, imm=16'hFFFC, and J-type op=2, jaddress=26'h0000010, then finish -> 32'h8FA8FFFC @0, 32'h08000010 @1, sentinel @2.
- Raw 32'hFFFFFFFF with finish=0 -> no mem_we, err=1, count unchanged; a subsequent valid word still writes at the same address.
- ADDR_W=4: 16 non-finish words -> words 0..14 written, 16th dropped with err=1; finish writes the sentinel @15; count=16.
- Reset asserted in the WRITE cycle of the 3rd word -> mem_we=0 that cycle, then count=0, ptr=0, err=0; the next word writes @0.
- Readback build with memory model corrupting address 1 -> err=1 after the VERIFY of word 2, and the loading continues normally.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: request handshake, instruction-memory write port and status of the instruction-memory loader
interface imem_loader_if #(parameter int ADDR_W = 10);
   logic              in_valid, in_ready, finish;
   logic [1:0]        fmt;
   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd, shamt;
   logic [15:0]       imm;
   logic [25:0]       jaddress;
   logic [31:0]       raw, mem_wdata, mem_rdata;
   logic              mem_we, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W:0]   count;
   modport slave (
      input  in_valid, finish, fmt, op, rs, rt, rd, shamt, funct, imm, jaddress, raw, mem_rdata,
      output in_ready, mem_we, mem_addr, mem_wdata, count, done, err
   );
   modport master (
      output in_valid, finish, fmt, op, rs, rt, rd, shamt, funct, imm, jaddress, raw, mem_rdata,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs field requests into MIPS R/I/J words, writes them from address 0 and ends with the halt sentinel; IMEM_LOADER_READBACK_EN adds a verify cycle per word
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input logic         clk,
   input logic         reset,
   imem_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
   state_t            state, state_n;
   logic [ADDR_W:0]   count_n;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       word, word_n, enc;
   logic              last, last_n, err_n, xfer;
   // the write pointer always equals the low bits of the written-word count
   assign ptr = bus.count[ADDR_W-1:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bus.count <= '0;
         word      <= '0;
         last      <= 1'b0;
         bus.err   <= 1'b0;
      end else begin
         state     <= state_n;
         bus.count <= count_n;
         word      <= word_n;
         last      <= last_n;
         bus.err   <= err_n;
      end
   end
   always_comb begin
      enc = bus.fmt == 2'b00 ? {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct} :
            bus.fmt == 2'b01 ? {bus.op, bus.rs, bus.rt, bus.imm} :
            bus.fmt == 2'b10 ? {bus.op, bus.jaddress} : bus.raw;
      state_n       = state;
      count_n       = bus.count;
      word_n        = word;
      last_n        = last;
      err_n         = bus.err;
      bus.in_ready  = (state == IDLE) & ~reset;
      bus.mem_we    = (state == WRITE) & ~reset;
      bus.mem_addr  = ptr;
      bus.mem_wdata = word;
      bus.done      = state == DONE;
      xfer          = bus.in_valid & bus.in_ready;
      case (state)
         IDLE: begin
            if (xfer && bus.finish) begin
               word_n  = '1;
               last_n  = 1'b1;
               state_n = WRITE;
            end else if (xfer) begin
               // last slot is reserved for the sentinel; a premature halt word is refused
               if (ptr == '1 || enc == '1) err_n = 1'b1;
               else begin
                  word_n  = enc;
                  last_n  = 1'b0;
                  state_n = WRITE;
               end
            end
         end
         WRITE: begin
            count_n = bus.count + 1'b1;
`ifdef IMEM_LOADER_READBACK_EN
            state_n = VERIFY;
`else
            state_n = last ? DONE : IDLE;
`endif
         end
`ifdef IMEM_LOADER_READBACK_EN
         VERIFY: begin
            bus.mem_addr = ptr - 1'b1;
            err_n        = bus.err | (bus.mem_rdata != word);
            state_n      = last ? DONE : IDLE;
         end
`endif
         default: ;
      endcase
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven check of field packing, rejection rules, fill limit and reset abort of imem_loader
module tb_imem_loader;
   localparam int AW = 4;
   typedef struct {
      logic        fin;
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] ja;
      logic [31:0] raw;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] data;
      logic        err;
      logic [4:0]  cnt;
      logic        done;
   } vec_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        corrupt = 1'b0;
   logic [31:0] mem [16];
   logic        s_we, s_rdy;
   logic [3:0]  s_addr;
   logic [31:0] s_data;
   int          n_vec = 0, n_bad = 0;
   vec_t        tab [7];
   imem_loader_if #(.ADDR_W(AW)) bus ();
   imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 4'd1) ? 32'h1 : 32'h0);
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic vec_t raw_v(input logic fin, input logic [31:0] w);
      vec_t r;
      r = '{default: '0};
      r.fin = fin;
      r.fmt = 2'b11;
      r.raw = w;
      return r;
   endfunction
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask
   // offers one request, samples the cycle after the accepting edge, then lets the loader settle
   task automatic send(input vec_t v);
      int k = 0;
      @(negedge clk);
      bus.finish = v.fin; bus.fmt = v.fmt; bus.op = v.op; bus.rs = v.rs; bus.rt = v.rt;
      bus.rd = v.rd; bus.shamt = v.sh; bus.funct = v.fn; bus.imm = v.imm; bus.jaddress = v.ja;
      bus.raw = v.raw;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         n_vec++;
         n_bad++;
         $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      s_we = bus.mem_we; s_addr = bus.mem_addr; s_data = bus.mem_wdata; s_rdy = bus.in_ready;
      @(posedge clk);
`ifdef IMEM_LOADER_READBACK_EN
      @(posedge clk);
`endif
      #1;
   endtask
   initial begin
      bus.in_valid = 1'b0;
      tab[0] = '{1'b0, 2'd0, 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0,
                 1'b1, 4'd0, 32'h01095020, 1'b0, 5'd1, 1'b0};
      tab[1] = '{1'b0, 2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0, 32'h0,
                 1'b1, 4'd1, 32'h8FA8FFFC, 1'b0, 5'd2, 1'b0};
      tab[2] = '{1'b0, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 32'h0,
                 1'b1, 4'd2, 32'h08000010, 1'b0, 5'd3, 1'b0};
      tab[3] = '{1'b0, 2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0, 32'hFFFFFFFF,
                 1'b0, 4'd3, 32'h0, 1'b1, 5'd3, 1'b0};
      tab[4] = '{1'b0, 2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0, 32'h12345678,
                 1'b1, 4'd3, 32'h12345678, 1'b1, 5'd4, 1'b0};
      tab[5] = '{1'b0, 2'd1, 6'h3F, 5'd31, 5'd31, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h0,
                 1'b0, 4'd4, 32'h0, 1'b1, 5'd4, 1'b0};
      tab[6] = '{1'b1, 2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0, 32'h00001234,
                 1'b1, 4'd4, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b1};
      @(posedge clk);
      #1;
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      reset = 1'b0;
      #1 chk("ready_after_rst", bus.in_ready, 1);
      for (int i = 0; i < 7; i++) begin
         send(tab[i]);
         chk($sformatf("v%0d_we", i), s_we, tab[i].we);
         chk($sformatf("v%0d_ready_next", i), s_rdy, !tab[i].we);
         if (tab[i].we) begin
            chk($sformatf("v%0d_addr", i), s_addr, tab[i].addr);
            chk($sformatf("v%0d_data", i), s_data, tab[i].data);
         end
         chk($sformatf("v%0d_err", i), bus.err, tab[i].err);
         chk($sformatf("v%0d_count", i), bus.count, tab[i].cnt);
         chk($sformatf("v%0d_done", i), bus.done, tab[i].done);
      end
      chk("mem0", mem[0], 32'h01095020);
      chk("mem1", mem[1], 32'h8FA8FFFC);
      chk("mem2", mem[2], 32'h08000010);
      chk("mem3", mem[3], 32'h12345678);
      chk("mem4", mem[4], 32'hFFFFFFFF);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.finish = 1'b0;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_ready", bus.in_ready, 0);
      chk("done_hold_count", bus.count, 5);
      chk("done_hold", bus.done, 1);
      // fill every slot: the 16th data word must be refused, the sentinel takes slot 15
      do_reset();
      for (int i = 0; i < 15; i++) begin
         send(raw_v(1'b0, 32'h100 + i));
         chk($sformatf("fill%0d_addr", i), {s_we, s_addr}, {1'b1, 4'(i)});
      end
      send(raw_v(1'b0, 32'hAA));
      chk("full_we", s_we, 0);
      chk("full_err", bus.err, 1);
      chk("full_count", bus.count, 15);
      send(raw_v(1'b1, 32'h0));
      chk("full_sent_addr", s_addr, 15);
      chk("full_sent_data", s_data, 32'hFFFFFFFF);
      chk("full_count_end", bus.count, 16);
      chk("full_done", bus.done, 1);
      chk("full_mem15", mem[15], 32'hFFFFFFFF);
      // reset in the WRITE cycle of the third word aborts it
      do_reset();
      send(raw_v(1'b0, 32'hA0A0));
      send(raw_v(1'b0, 32'hB0B0));
      @(negedge clk);
      bus.finish = 1'b0; bus.fmt = 2'b11; bus.raw = 32'hC0C0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      reset = 1'b1;
      #1 chk("abort_we", bus.mem_we, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_count", bus.count, 0);
      chk("abort_err", bus.err, 0);
      chk("abort_ready", bus.in_ready, 1);
      chk("abort_mem2", mem[2], 32'h102);
      send(raw_v(1'b0, 32'hD0D0));
      chk("abort_next_addr", {s_we, s_addr}, {1'b1, 4'd0});
      chk("abort_mem0", mem[0], 32'hD0D0);
      chk("abort_mem1", mem[1], 32'hB0B0);
`ifdef IMEM_LOADER_READBACK_EN
      do_reset();
      corrupt = 1'b1;
      send(raw_v(1'b0, 32'h1111));
      chk("rb_w1_err", bus.err, 0);
      send(raw_v(1'b0, 32'h2222));
      chk("rb_w2_err", bus.err, 1);
      send(raw_v(1'b0, 32'h3333));
      chk("rb_w3_addr", {s_we, s_addr}, {1'b1, 4'd2});
      send(raw_v(1'b1, 32'h0));
      chk("rb_done", bus.done, 1);
      chk("rb_count", bus.count, 4);
      chk("rb_mem1", mem[1], 32'h2222);
      corrupt = 1'b0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
